// File: rtl/rs_pkg.sv
// Shared types and defaults for the reservation-station issue scheduler.
package rs_pkg;

  localparam int RS_ENTRIES_DEF = 16;
  localparam int PREG_WIDTH_DEF = 6;
  localparam int WAKE_PORTS_DEF = 2;

  localparam logic FU_ALU = 1'b0;
  localparam logic FU_MEM = 1'b1;

  // Per-slot control state. Tags are stored at the package default width;
  // the scheduler's PREG_WIDTH parameter must not exceed it.
  typedef struct packed {
    logic                      valid;
    logic                      fu;
    logic [PREG_WIDTH_DEF-1:0] rs1_tag;
    logic                      rs1_rdy;
    logic [PREG_WIDTH_DEF-1:0] rs2_tag;
    logic                      rs2_rdy;
  } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Picks the oldest requester out of an eligible vector using an age matrix.
// older_i[j][i] = 1 means entry j is older than entry i.
module rs_oldest_select #(
  parameter int N      = 16,
  parameter int SLOT_W = $clog2(N)
) (
  input  logic [N-1:0]        elig_i,
  input  logic [N-1:0][N-1:0] older_i,
  output logic [N-1:0]        grant_o,
  output logic [SLOT_W-1:0]   slot_o,
  output logic                any_o
);

  // blocker[i][j]: eligible entry j is older than entry i, so i must wait
  logic [N-1:0][N-1:0] blocker;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        assign blocker[gi][gj] = elig_i[gj] & older_i[gj][gi];
      end
      assign grant_o[gi] = elig_i[gi] & ~(|blocker[gi]);
    end
  endgenerate

  assign any_o = |elig_i;

  // Encode the one-hot grant; an empty grant encodes to slot 0
  always_comb begin
    slot_o = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_o[i]) slot_o = slot_o | SLOT_W'(i);
    end
  end

endmodule

// File: rtl/rs_issue_sched.sv
// Reservation-station scheduler: slot allocation, tag wakeup, oldest-first
// select per FU class, issue handshakes and flush. No payload is held here.
module rs_issue_sched
  import rs_pkg::*;
#(
  parameter int RS_ENTRIES = RS_ENTRIES_DEF,
  parameter int PREG_WIDTH = PREG_WIDTH_DEF,
  parameter int WAKE_PORTS = WAKE_PORTS_DEF,
  parameter int SLOT_W     = $clog2(RS_ENTRIES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  input  logic                             alloc_fu,
  input  logic [PREG_WIDTH-1:0]            alloc_rs1_tag,
  input  logic                             alloc_rs1_rdy,
  input  logic [PREG_WIDTH-1:0]            alloc_rs2_tag,
  input  logic                             alloc_rs2_rdy,
  output logic [SLOT_W-1:0]                alloc_slot,
  input  logic [WAKE_PORTS-1:0]            wake_valid,
  input  logic [WAKE_PORTS*PREG_WIDTH-1:0] wake_tag,
  output logic                             alu_issue_valid,
  output logic [SLOT_W-1:0]                alu_issue_slot,
  input  logic                             alu_issue_ready,
  output logic                             mem_issue_valid,
  output logic [SLOT_W-1:0]                mem_issue_slot,
  input  logic                             mem_issue_ready,
  output logic [SLOT_W:0]                  occupancy
);

  rs_entry_t                             entries_q [RS_ENTRIES];
  rs_entry_t                             entries_d [RS_ENTRIES];
  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] older_q, older_d;
  logic [SLOT_W:0]                       occ_q, occ_d;

  logic [RS_ENTRIES-1:0] valid_vec, alu_elig, mem_elig, alu_grant, mem_grant;
  logic [SLOT_W-1:0]     free_slot;
  logic                  alloc_fire, alu_fire, mem_fire;

  // True when any valid broadcast port carries the given tag
  function automatic logic tag_woken(
    input logic [PREG_WIDTH-1:0]            tag,
    input logic [WAKE_PORTS-1:0]            wv,
    input logic [WAKE_PORTS*PREG_WIDTH-1:0] wt
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (wv[p] && (wt[p*PREG_WIDTH +: PREG_WIDTH] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < RS_ENTRIES; gi++) begin : g_elig
      assign valid_vec[gi] = entries_q[gi].valid;
      assign alu_elig[gi]  = entries_q[gi].valid && entries_q[gi].rs1_rdy &&
                             entries_q[gi].rs2_rdy && (entries_q[gi].fu == FU_ALU);
      assign mem_elig[gi]  = entries_q[gi].valid && entries_q[gi].rs1_rdy &&
                             entries_q[gi].rs2_rdy && (entries_q[gi].fu == FU_MEM);
    end
  endgenerate

  rs_oldest_select #(.N(RS_ENTRIES), .SLOT_W(SLOT_W)) u_alu_sel (
    .elig_i  (alu_elig),
    .older_i (older_q),
    .grant_o (alu_grant),
    .slot_o  (alu_issue_slot),
    .any_o   (alu_issue_valid)
  );

  rs_oldest_select #(.N(RS_ENTRIES), .SLOT_W(SLOT_W)) u_mem_sel (
    .elig_i  (mem_elig),
    .older_i (older_q),
    .grant_o (mem_grant),
    .slot_o  (mem_issue_slot),
    .any_o   (mem_issue_valid)
  );

  // Lowest-index free slot from registered state; slots freed this cycle
  // therefore only become allocatable next cycle
  always_comb begin
    free_slot = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) free_slot = SLOT_W'(i);
    end
  end

  assign alloc_ready = (occ_q != (SLOT_W+1)'(RS_ENTRIES));
  assign alloc_slot  = free_slot;
  assign occupancy   = occ_q;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alu_fire    = alu_issue_valid && alu_issue_ready;
  assign mem_fire    = mem_issue_valid && mem_issue_ready;

  // Next-state: wakeup, issue invalidation, allocation with bypass, flush
  always_comb begin
    entries_d = entries_q;
    older_d   = older_q;
    occ_d     = occ_q + (SLOT_W+1)'(alloc_fire)
                      - (SLOT_W+1)'(alu_fire) - (SLOT_W+1)'(mem_fire);

    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (entries_q[i].valid) begin
        if (!entries_q[i].rs1_rdy &&
            tag_woken(PREG_WIDTH'(entries_q[i].rs1_tag), wake_valid, wake_tag))
          entries_d[i].rs1_rdy = 1'b1;
        if (!entries_q[i].rs2_rdy &&
            tag_woken(PREG_WIDTH'(entries_q[i].rs2_tag), wake_valid, wake_tag))
          entries_d[i].rs2_rdy = 1'b1;
      end
      if ((alu_fire && alu_grant[i]) || (mem_fire && mem_grant[i]))
        entries_d[i].valid = 1'b0;
    end

    if (alloc_fire) begin
      entries_d[free_slot].valid   = 1'b1;
      entries_d[free_slot].fu      = alloc_fu;
      entries_d[free_slot].rs1_tag = PREG_WIDTH_DEF'(alloc_rs1_tag);
      entries_d[free_slot].rs1_rdy = alloc_rs1_rdy ||
                                     tag_woken(alloc_rs1_tag, wake_valid, wake_tag);
      entries_d[free_slot].rs2_tag = PREG_WIDTH_DEF'(alloc_rs2_tag);
      entries_d[free_slot].rs2_rdy = alloc_rs2_rdy ||
                                     tag_woken(alloc_rs2_tag, wake_valid, wake_tag);
      // Every currently valid entry is older than the newcomer
      for (int k = 0; k < RS_ENTRIES; k++) begin
        older_d[k][free_slot] = valid_vec[k];
      end
      older_d[free_slot] = '0;
    end

    // Age bits of invalid entries are never consulted, so flush leaves them
    if (flush) begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        entries_d[i].valid = 1'b0;
      end
      occ_d = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
      older_q <= '0;
      occ_q   <= '0;
    end else begin
      entries_q <= entries_d;
      older_q   <= older_d;
      occ_q     <= occ_d;
    end
  end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Self-checking bench for rs_issue_sched with a sequence-number based model.
module tb_rs_issue_sched;

  localparam int N  = 16;
  localparam int PW = 6;
  localparam int WP = 2;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, alloc_valid, alloc_ready, alloc_fu;
  logic [PW-1:0] alloc_rs1_tag, alloc_rs2_tag;
  logic          alloc_rs1_rdy, alloc_rs2_rdy;
  logic [SW-1:0] alloc_slot;
  logic [WP-1:0] wake_valid;
  logic [WP*PW-1:0] wake_tag;
  logic          alu_issue_valid, alu_issue_ready, mem_issue_valid, mem_issue_ready;
  logic [SW-1:0] alu_issue_slot, mem_issue_slot;
  logic [SW:0]   occupancy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rs_issue_sched dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_fu(alloc_fu),
    .alloc_rs1_tag(alloc_rs1_tag), .alloc_rs1_rdy(alloc_rs1_rdy),
    .alloc_rs2_tag(alloc_rs2_tag), .alloc_rs2_rdy(alloc_rs2_rdy),
    .alloc_slot(alloc_slot), .wake_valid(wake_valid), .wake_tag(wake_tag),
    .alu_issue_valid(alu_issue_valid), .alu_issue_slot(alu_issue_slot),
    .alu_issue_ready(alu_issue_ready),
    .mem_issue_valid(mem_issue_valid), .mem_issue_slot(mem_issue_slot),
    .mem_issue_ready(mem_issue_ready), .occupancy(occupancy)
  );

  // Reference model: each entry carries an allocation sequence number;
  // the oldest is the eligible entry with the smallest number.
  bit m_valid [N];
  bit m_fu    [N];
  int m_t1    [N];
  int m_t2    [N];
  bit m_r1    [N];
  bit m_r2    [N];
  int m_seq   [N];
  int seq_ctr = 0;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  function automatic int m_pick(bit fu);
    int best = -1;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_r1[i] && m_r2[i] && m_fu[i] == fu)
        if (best < 0 || m_seq[i] < m_seq[best]) best = i;
    end
    return best;
  endfunction

  function automatic bit m_hit(int tag);
    for (int p = 0; p < WP; p++)
      if (wake_valid[p] && int'(wake_tag[p*PW +: PW]) == tag) return 1'b1;
    return 1'b0;
  endfunction

  // Expected packed output vector derived from the model
  function automatic logic [3*SW+SW+4:0] m_expect();
    int ap, mp;
    ap = m_pick(1'b0);
    mp = m_pick(1'b1);
    return {m_count() != N, SW'(m_free()),
            ap >= 0, SW'((ap >= 0) ? ap : 0),
            mp >= 0, SW'((mp >= 0) ? mp : 0),
            (SW+1)'(m_count())};
  endfunction

  // One clock edge: the model evolves from the inputs present at the edge
  task automatic tick();
    int  ap, mp, cnt, fs;
    bit  h1 [N];
    bit  h2 [N];
    ap  = m_pick(1'b0);
    mp  = m_pick(1'b1);
    cnt = m_count();
    fs  = m_free();
    for (int i = 0; i < N; i++) begin
      h1[i] = m_hit(m_t1[i]);
      h2[i] = m_hit(m_t2[i]);
    end
    @(posedge clk);
    if (rst || flush) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_valid[i] && h1[i]) m_r1[i] = 1'b1;
        if (m_valid[i] && h2[i]) m_r2[i] = 1'b1;
      end
      if (ap >= 0 && alu_issue_ready) m_valid[ap] = 1'b0;
      if (mp >= 0 && mem_issue_ready) m_valid[mp] = 1'b0;
      if (alloc_valid && cnt != N) begin
        m_valid[fs] = 1'b1;
        m_fu[fs]    = alloc_fu;
        m_t1[fs]    = int'(alloc_rs1_tag);
        m_t2[fs]    = int'(alloc_rs2_tag);
        m_r1[fs]    = alloc_rs1_rdy | m_hit(int'(alloc_rs1_tag));
        m_r2[fs]    = alloc_rs2_rdy | m_hit(int'(alloc_rs2_tag));
        m_seq[fs]   = seq_ctr++;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    rst = 0; flush = 0; alloc_valid = 0; alloc_fu = 0;
    alloc_rs1_tag = '0; alloc_rs1_rdy = 0; alloc_rs2_tag = '0; alloc_rs2_rdy = 0;
    wake_valid = '0; wake_tag = '0; alu_issue_ready = 0; mem_issue_ready = 0;
  endtask

  task automatic set_alloc(bit fu, int t1, bit r1, int t2, bit r2);
    alloc_valid = 1; alloc_fu = fu;
    alloc_rs1_tag = PW'(t1); alloc_rs1_rdy = r1;
    alloc_rs2_tag = PW'(t2); alloc_rs2_rdy = r2;
  endtask

  task automatic clear_state();
    set_idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    n_checks++;
    if ({alloc_ready, alloc_slot, alu_issue_valid, alu_issue_slot,
         mem_issue_valid, mem_issue_slot, occupancy} !== {1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0}) begin
      n_errors++;
      $display("FAIL reset_outputs: got rdy=%0b slot=%0d aluv=%0b alus=%0d memv=%0b mems=%0d occ=%0d, want 1 0 0 0 0 0 0",
               alloc_ready, alloc_slot, alu_issue_valid, alu_issue_slot, mem_issue_valid, mem_issue_slot, occupancy);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_issue();
    clear_state();
    set_alloc(0, 1, 1, 2, 1);
    n_checks++;
    if (alloc_slot !== 4'd0) begin n_errors++; $display("FAIL basic_alloc_slot: got %0d want 0", alloc_slot); end
    tick();
    set_idle();
    n_checks++;
    if (occupancy !== 5'd1) begin n_errors++; $display("FAIL basic_occ1: got %0d want 1", occupancy); end
    n_checks++;
    if ({alu_issue_valid, alu_issue_slot} !== {1'b1, 4'd0}) begin
      n_errors++; $display("FAIL basic_issue: got v=%0b s=%0d want v=1 s=0", alu_issue_valid, alu_issue_slot);
    end
    alu_issue_ready = 1;
    tick();
    set_idle();
    n_checks++;
    if ({occupancy, alu_issue_valid} !== {5'd0, 1'b0}) begin
      n_errors++; $display("FAIL basic_drain: got occ=%0d v=%0b want occ=0 v=0", occupancy, alu_issue_valid);
    end
    $display("test_basic_issue done");
  endtask

  task automatic test_in_order();
    clear_state();
    for (int k = 0; k < 3; k++) begin
      set_alloc(0, 0, 1, 0, 1);
      n_checks++;
      if (alloc_slot !== SW'(k)) begin n_errors++; $display("FAIL order_alloc_slot: got %0d want %0d", alloc_slot, k); end
      tick();
    end
    set_idle();
    alu_issue_ready = 1;
    n_checks++;
    if ({alu_issue_valid, alu_issue_slot} !== {1'b1, 4'd0}) begin
      n_errors++; $display("FAIL order_issue0: got v=%0b s=%0d want v=1 s=0", alu_issue_valid, alu_issue_slot);
    end
    tick();
    // Slot 0 was freed at that edge; refill it while slot 1 issues
    set_alloc(0, 0, 1, 0, 1);
    n_checks++;
    if ({alu_issue_slot, alloc_slot} !== {4'd1, 4'd0}) begin
      n_errors++; $display("FAIL order_issue1_realloc: got s=%0d alloc=%0d want s=1 alloc=0", alu_issue_slot, alloc_slot);
    end
    tick();
    alloc_valid = 0;
    n_checks++;
    if (alu_issue_slot !== 4'd2) begin n_errors++; $display("FAIL order_older_first: got %0d want 2", alu_issue_slot); end
    tick();
    n_checks++;
    if ({alu_issue_valid, alu_issue_slot} !== {1'b1, 4'd0}) begin
      n_errors++; $display("FAIL order_young_last: got v=%0b s=%0d want v=1 s=0", alu_issue_valid, alu_issue_slot);
    end
    tick();
    set_idle();
    n_checks++;
    if (occupancy !== 5'd0) begin n_errors++; $display("FAIL order_drain: got %0d want 0", occupancy); end
    $display("test_in_order done");
  endtask

  task automatic test_wake_bypass();
    clear_state();
    set_alloc(0, 5, 0, 3, 1);
    wake_valid = 2'b10;
    wake_tag   = {6'd5, 6'd0};
    tick();
    set_idle();
    n_checks++;
    if ({alu_issue_valid, alu_issue_slot} !== {1'b1, 4'd0}) begin
      n_errors++; $display("FAIL bypass_issue: got v=%0b s=%0d want v=1 s=0", alu_issue_valid, alu_issue_slot);
    end
    alu_issue_ready = 1;
    tick();
    set_idle();
    // Wake arrives one cycle after allocation
    set_alloc(0, 7, 0, 3, 1);
    tick();
    set_idle();
    wake_valid = 2'b01;
    wake_tag   = {6'd0, 6'd7};
    n_checks++;
    if (alu_issue_valid !== 1'b0) begin n_errors++; $display("FAIL late_wake_early: got %0b want 0", alu_issue_valid); end
    tick();
    set_idle();
    n_checks++;
    if ({alu_issue_valid, alu_issue_slot} !== {1'b1, 4'd0}) begin
      n_errors++; $display("FAIL late_wake_issue: got v=%0b s=%0d want v=1 s=0", alu_issue_valid, alu_issue_slot);
    end
    $display("test_wake_bypass done");
  endtask

  task automatic test_full();
    clear_state();
    for (int k = 0; k < N; k++) begin
      set_alloc(bit'(k % 2), 0, 1, 0, 1);
      n_checks++;
      if (alloc_slot !== SW'(k)) begin n_errors++; $display("FAIL full_alloc_slot: got %0d want %0d", alloc_slot, k); end
      tick();
    end
    n_checks++;
    if ({alloc_ready, occupancy} !== {1'b0, 5'd16}) begin
      n_errors++; $display("FAIL full_state: got rdy=%0b occ=%0d want rdy=0 occ=16", alloc_ready, occupancy);
    end
    tick();
    n_checks++;
    if (occupancy !== 5'd16) begin n_errors++; $display("FAIL full_ignored: got %0d want 16", occupancy); end
    alu_issue_ready = 1;
    mem_issue_ready = 1;
    n_checks++;
    if ({alu_issue_slot, mem_issue_slot} !== {4'd0, 4'd1}) begin
      n_errors++; $display("FAIL full_dual_cand: got alu=%0d mem=%0d want 0 1", alu_issue_slot, mem_issue_slot);
    end
    tick();
    alu_issue_ready = 0;
    mem_issue_ready = 0;
    n_checks++;
    if ({occupancy, alloc_ready, alloc_slot} !== {5'd14, 1'b1, 4'd0}) begin
      n_errors++; $display("FAIL full_dual_issue: got occ=%0d rdy=%0b slot=%0d want 14 1 0", occupancy, alloc_ready, alloc_slot);
    end
    tick();
    set_idle();
    n_checks++;
    if ({occupancy, alloc_slot} !== {5'd15, 4'd1}) begin
      n_errors++; $display("FAIL full_refill: got occ=%0d slot=%0d want 15 1", occupancy, alloc_slot);
    end
    $display("test_full done");
  endtask

  task automatic test_class_order();
    clear_state();
    set_alloc(1, 40, 0, 0, 1); tick();   // slot0 MEM, blocked
    set_alloc(0, 0, 1, 0, 1);  tick();   // slot1 ALU, ready
    set_alloc(1, 0, 1, 0, 1);  tick();   // slot2 MEM, ready
    set_alloc(0, 9, 0, 0, 1);  tick();   // slot3 ALU A, waits on tag 9
    set_idle();
    alu_issue_ready = 1;
    n_checks++;
    if ({alu_issue_slot, mem_issue_slot} !== {4'd1, 4'd2}) begin
      n_errors++; $display("FAIL class_cand: got alu=%0d mem=%0d want 1 2", alu_issue_slot, mem_issue_slot);
    end
    tick();
    set_idle();
    set_alloc(0, 0, 1, 0, 1);            // B lands in slot1, younger than A
    n_checks++;
    if (alloc_slot !== 4'd1) begin n_errors++; $display("FAIL class_b_slot: got %0d want 1", alloc_slot); end
    tick();
    set_idle();
    n_checks++;
    if ({alu_issue_valid, alu_issue_slot} !== {1'b1, 4'd1}) begin
      n_errors++; $display("FAIL class_b_first: got v=%0b s=%0d want v=1 s=1", alu_issue_valid, alu_issue_slot);
    end
    alu_issue_ready = 1;
    tick();
    set_idle();
    set_alloc(0, 0, 1, 0, 1);            // C in slot1, plus wake A
    wake_valid = 2'b01;
    wake_tag   = {6'd0, 6'd9};
    tick();
    set_idle();
    n_checks++;
    if ({alu_issue_valid, alu_issue_slot, mem_issue_slot} !== {1'b1, 4'd3, 4'd2}) begin
      n_errors++; $display("FAIL class_a_oldest: got v=%0b alu=%0d mem=%0d want 1 3 2", alu_issue_valid, alu_issue_slot, mem_issue_slot);
    end
    alu_issue_ready = 1;
    tick();
    set_idle();
    n_checks++;
    if (alu_issue_slot !== 4'd1) begin n_errors++; $display("FAIL class_c_after: got %0d want 1", alu_issue_slot); end
    $display("test_class_order done");
  endtask

  task automatic test_flush_rst();
    clear_state();
    for (int k = 0; k < 6; k++) begin set_alloc(bit'(k % 2), 0, 1, 0, 1); tick(); end
    set_alloc(0, 0, 1, 0, 1);
    alu_issue_ready = 1; mem_issue_ready = 1; flush = 1;
    wake_valid = 2'b11;
    tick();
    set_idle();
    n_checks++;
    if ({occupancy, alu_issue_valid, mem_issue_valid, alloc_slot, alloc_ready} !== {5'd0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
      n_errors++; $display("FAIL flush_state: got occ=%0d aluv=%0b memv=%0b slot=%0d rdy=%0b want 0 0 0 0 1",
                           occupancy, alu_issue_valid, mem_issue_valid, alloc_slot, alloc_ready);
    end
    for (int k = 0; k < 3; k++) begin set_alloc(bit'(k % 2), 0, 1, 0, 1); tick(); end
    set_alloc(1, 0, 1, 0, 1);
    alu_issue_ready = 1; flush = 1; rst = 1;
    tick();
    set_idle();
    n_checks++;
    if ({occupancy, alu_issue_valid, mem_issue_valid, alloc_slot} !== {5'd0, 1'b0, 1'b0, 4'd0}) begin
      n_errors++; $display("FAIL rst_midrun: got occ=%0d aluv=%0b memv=%0b slot=%0d want 0 0 0 0",
                           occupancy, alu_issue_valid, mem_issue_valid, alloc_slot);
    end
    $display("test_flush_rst done");
  endtask

  task automatic test_random();
    logic [3*SW+SW+4:0] exp_v, got_v;
    clear_state();
    for (int c = 0; c < 1500; c++) begin
      set_idle();
      rst             = ($urandom_range(0, 299) == 0);
      flush           = ($urandom_range(0, 63) == 0);
      alloc_valid     = ($urandom_range(0, 9) < 6);
      alloc_fu        = 1'($urandom_range(0, 1));
      alloc_rs1_tag   = PW'($urandom_range(0, 7));
      alloc_rs2_tag   = PW'($urandom_range(0, 7));
      alloc_rs1_rdy   = ($urandom_range(0, 9) < 4);
      alloc_rs2_rdy   = ($urandom_range(0, 9) < 4);
      wake_valid      = WP'($urandom_range(0, 3));
      wake_tag        = {PW'($urandom_range(0, 7)), PW'($urandom_range(0, 7))};
      alu_issue_ready = ($urandom_range(0, 1) == 1);
      mem_issue_ready = ($urandom_range(0, 1) == 1);
      exp_v = m_expect();
      got_v = {alloc_ready, alloc_slot, alu_issue_valid, alu_issue_slot,
               mem_issue_valid, mem_issue_slot, occupancy};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL random_cycle%0d: got {rdy,slot,aluv,alus,memv,mems,occ}=%h want %h", c, got_v, exp_v);
      end
      tick();
    end
    set_idle();
    $display("test_random done");
  endtask

  initial begin
    set_idle();
    test_reset();
    test_basic_issue();
    test_in_order();
    test_wake_bypass();
    test_full();
    test_class_order();
    test_flush_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rs_issue_sched.md
Name: rs_issue_sched

Overview:
- Control-only scheduler for the reservation station between rename/dispatch and the execution units (ALU, LSQ/memory port).
- Tracks source-tag readiness per slot and wakes sources on completion broadcasts.
- Each cycle selects the oldest ready entry per functional-unit class and hands its slot index to the payload RAM and FU.
- Owns slot allocation, age ordering, issue handshakes and flush. Holds no instruction payload.

Parameters:
RS_ENTRIES, 16, number of scheduler slots (power of 2)
PREG_WIDTH, 6, physical register tag width
WAKE_PORTS, 2, number of completion/wakeup broadcast ports
SLOT_W, $clog2(RS_ENTRIES), slot index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  discard all entries
alloc_valid  in  1  dispatch requests a slot
alloc_ready  out  1  a free slot exists
alloc_fu  in  1  FU class: 0=ALU, 1=MEM
alloc_rs1_tag  in  PREG_WIDTH  source 1 physical tag
alloc_rs1_rdy  in  1  source 1 already ready
alloc_rs2_tag  in  PREG_WIDTH  source 2 physical tag
alloc_rs2_rdy  in  1  source 2 already ready
alloc_slot  out  SLOT_W  slot granted this cycle (payload write index)
wake_valid  in  WAKE_PORTS  per-port broadcast valid
wake_tag  in  WAKE_PORTS*PREG_WIDTH  packed broadcast tags, port 0 in LSBs
alu_issue_valid  out  1  ALU candidate present
alu_issue_slot  out  SLOT_W  ALU candidate slot
alu_issue_ready  in  1  ALU accepts
mem_issue_valid  out  1  MEM candidate present
mem_issue_slot  out  SLOT_W  MEM candidate slot
mem_issue_ready  in  1  MEM accepts
occupancy  out  SLOT_W+1  number of valid entries

Behaviour:
- Reset (rst=1 at a clock edge): all entries invalid and the age matrix cleared.
  - Outputs after reset: alloc_ready=1, alloc_slot=0, issue valids 0, issue slots 0, occupancy 0.
- Per-entry state: valid, fu, rs1_tag, rs1_rdy, rs2_tag, rs2_rdy. Age matrix bit older[i][j] means entry i is older than entry j.
- Allocation:
  - alloc_ready = (occupancy != RS_ENTRIES), computed from registered state only.
  - alloc_slot is combinational: the lowest-index invalid slot.
  - On alloc_valid && alloc_ready the entry is written at the edge. The new entry becomes younger than every valid entry: older[k][new]=1 for all valid k, older[new][*]=0.
  - alloc_valid while full: ignored, no state change.
- Wakeup:
  - For each valid entry source with rdy=0, any port p with wake_valid[p] and a matching tag sets rdy at the edge.
  - The same comparison is applied to alloc tags in the same cycle (alloc-wakeup bypass), so a source woken during its own allocation cycle is stored ready.
  - Duplicate tags across ports are legal.
- Select:
  - Eligible means valid && rs1_rdy && rs2_rdy && fu matches the class.
  - The candidate is the eligible entry with no eligible older entry of the same class.
  - issue_valid and issue_slot are combinational from registered state. An entry woken in cycle N is first eligible in N+1 (one-cycle wakeup-to-issue).
  - issue_slot is 0 when issue_valid=0.
- Issue handshake:
  - On issue_valid && issue_ready the slot is invalidated at the edge. Without ready, the candidate stays stable (unless an older entry becomes eligible).
  - ALU and MEM may both issue in one cycle.
  - A slot freed this cycle is not reallocatable until the next cycle.
- Occupancy: next = occ + alloc_fire − alu_fire − mem_fire. Allocation and up to two issues in the same cycle are legal.
- Flush: at the edge, all entries are invalidated and occupancy goes to 0.
  - Flush overrides alloc, issue and wakeup in that cycle.
  - Issue outputs may be asserted during the flush cycle. The consumer ignores them.
- rst has priority over flush.

Decomposition:
- Shared package rs_pkg:
  - FU_ALU=1'b0, FU_MEM=1'b1.
  - rs_entry_t struct (valid, fu, tags, rdy bits).
  - Default RS_ENTRIES / PREG_WIDTH / WAKE_PORTS constants.
- One sub-module, rs_oldest_select:
  - Inputs: eligible vector and age matrix. Outputs: one-hot grant, encoded slot, any-valid.
  - Instantiated twice (ALU, MEM).
- Tag compare and age-matrix update stay inline.

Test Plan:
- Reset, then alloc ALU with rs1_rdy=rs2_rdy=1 in cycle 1.
  - Required: alloc_slot=0, occupancy=1 after the edge.
  - Required: alu_issue_valid=1, slot 0 in cycle 2; with alu_issue_ready=1, occupancy=0 in cycle 3.
- Alloc slots 0,1,2 (ALU, all ready) with alu_issue_ready=0 for 3 cycles, then ready=1.
  - Required: issues in order 0,1,2, one per cycle.
  - Then alloc into a freed slot 0: it issues after older slots only if older ones remain.
- Alloc ALU with rs1_tag=5 not ready while wake_valid[1]=1, wake_tag port1=5 in the same cycle.
  - Required: entry stored ready and issues the next cycle.
  - Variant with wake one cycle later: issue is 1 cycle later.
- Fill all 16 slots (alloc_ready drops to 0 after the 16th), then assert alloc_valid.
  - Required: ignored.
  - Then issue one ALU and one MEM in the same cycle while alloc_valid=1: occupancy goes 16→14, alloc_ready=1 next cycle, and the next alloc grants the lowest freed slot.
- Oldest-first by class: ALU entry A in slot 3 (older, waiting on tag 9) and ALU entry B in slot 1 (ready).
  - Required: B issues first.
  - After wake on tag 9, A issues. MEM entries are unaffected by ALU readiness.
- Flush with 6 valid entries, alloc_valid=1 and both issue_ready=1 in the same cycle.
  - Required: next cycle occupancy=0, all issue_valid=0, alloc_slot=0.
  - rst asserted mid-run gives the same result.
